// File: rtl/fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_pkg : shared state encoding and defaults for fetch stage  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package fetch_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_HOLD   = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALTED = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic isMisaligned(input logic [1:0] lsbs);
    return |(lsbs & ALIGN_MASK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pc_reg : load-enabled register, async active-high reset value   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module pc_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | instr_fetch_unit : one-at-a-time fetch, PC owner, decode feed   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  output logic [ADDR_W-1:0] seqPC,
  output logic [ADDR_W-1:0] curPC,
  input  logic [ADDR_W-1:0] nextAddr,
  input  logic              nextValid,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemGnt,
  input  logic              imemValid,
  input  logic [ADDR_W-1:0] imemData,
  output logic [ADDR_W-1:0] instr,
  output logic              instrValid,
  input  logic              instrReady,
  output logic              fault,
  output logic [ADDR_W-1:0] retired
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_stateNext;
  logic [ADDR_W-1:0]  w_pc;
  logic [ADDR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]  r_retired;
  logic               r_fault;
  logic               w_retire;
  logic               w_misaligned;
  logic               w_pcLoad;

  assign w_retire     = (r_state == ST_HOLD) && instrReady && nextValid;
  assign w_misaligned = isMisaligned(nextAddr[1:0]);
  // A misaligned target never reaches the PC; the old PC is kept for debug.
  assign w_pcLoad     = w_retire && !w_misaligned;

  pc_reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pcReg (
    .clk  (clk),
    .rst  (rst),
    .load (w_pcLoad),
    .d    (nextAddr),
    .q    (w_pc)
  );

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_stateNext = ST_REQ;
      end
      ST_REQ: begin
        if (imemGnt) w_stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (imemValid) w_stateNext = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_retire) begin
          if (w_misaligned || halt) w_stateNext = ST_HALTED;
          else                      w_stateNext = ST_REQ;
        end
      end
      ST_HALTED: begin
        if (start && !r_fault) w_stateNext = ST_REQ;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_instr   <= '0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_stateNext;
      if ((r_state == ST_WAIT) && imemValid) begin
        r_instr <= imemData;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
        if (w_misaligned) r_fault <= 1'b1;
      end
    end
  end

  assign imemReq    = (r_state == ST_REQ);
  assign imemAddr   = (r_state == ST_REQ) ? w_pc : '0;
  assign instrValid = (r_state == ST_HOLD);
  assign instr      = r_instr;
  assign fault      = r_fault;
  assign retired    = r_retired;
  assign curPC      = w_pc;
  assign seqPC      = w_pc + PC_STEP;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_instr_fetch_unit : directed self-checking bench              |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt;
  logic [31:0] seqPC, curPC, nextAddr;
  logic        nextValid;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt, imemValid;
  logic [31:0] imemData, instr;
  logic        instrValid, instrReady, fault;
  logic [31:0] retired;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expRetired  = 32'd0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt       (halt),
    .seqPC      (seqPC),
    .curPC      (curPC),
    .nextAddr   (nextAddr),
    .nextValid  (nextValid),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemGnt    (imemGnt),
    .imemValid  (imemValid),
    .imemData   (imemData),
    .instr      (instr),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .fault      (fault),
    .retired    (retired)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from REQ: grant, data next cycle, then retire.
  task automatic doFetch(input logic [31:0] data, input logic [31:0] next,
                         input logic hlt, input logic strt);
    imemGnt = 1'b1;
    tick();
    imemGnt   = 1'b0;
    checkEq("waitNoReq", imemReq, 1'b0);
    imemValid = 1'b1;
    imemData  = data;
    tick();
    imemValid = 1'b0;
    checkEq("holdValid", instrValid, 1'b1);
    checkEq("holdInstr", instr, data);
    instrReady = 1'b1;
    nextValid  = 1'b1;
    nextAddr   = next;
    halt       = hlt;
    start      = strt;
    tick();
    instrReady = 1'b0;
    nextValid  = 1'b0;
    halt       = 1'b0;
    start      = 1'b0;
    expRetired = expRetired + 32'd1;
    checkEq("retired", retired, expRetired);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; nextAddr = '0; nextValid = 1'b0;
    imemGnt = 1'b0; imemValid = 1'b0; imemData = '0; instrReady = 1'b0;
    tick();
    tick();
    checkEq("rstReq",     imemReq,    1'b0);
    checkEq("rstIValid",  instrValid, 1'b0);
    checkEq("rstPC",      curPC,      32'h0);
    checkEq("rstSeqPC",   seqPC,      32'h4);
    checkEq("rstInstr",   instr,      32'h0);
    checkEq("rstFault",   fault,      1'b0);
    checkEq("rstRetired", retired,    32'h0);
    rst = 1'b0;
    tick();
    checkEq("idleNoReq", imemReq, 1'b0);

    // Basic fetch, 3 cycles per instruction
    start = 1'b1;
    tick();
    start = 1'b0;
    checkEq("req0", imemReq, 1'b1);
    checkEq("addr0", imemAddr, 32'h0);
    doFetch(32'h2001_0005, 32'h4, 1'b0, 1'b0);
    checkEq("req4", imemReq, 1'b1);
    checkEq("addr4", imemAddr, 32'h4);
    checkEq("curPC4", curPC, 32'h4);

    // Partial handshakes must not retire
    doFetch(32'h1111_2222, 32'h10, 1'b0, 1'b0);
    checkEq("addr10", imemAddr, 32'h10);
    imemGnt = 1'b1;
    tick();
    imemGnt = 1'b0; imemValid = 1'b1; imemData = 32'hAAAA_5555;
    tick();
    imemValid  = 1'b0;
    imemData   = 32'h0BAD_0BAD;
    instrReady = 1'b1;
    nextValid  = 1'b0;
    nextAddr   = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkEq("stallValid", instrValid, 1'b1);
      checkEq("stallInstr", instr, 32'hAAAA_5555);
    end
    instrReady = 1'b0;
    nextValid  = 1'b1;
    tick();
    checkEq("stallRev", instrValid, 1'b1);
    checkEq("stallRetired", retired, expRetired);
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
    nextValid  = 1'b0;
    expRetired = expRetired + 32'd1;
    checkEq("addr40", imemAddr, 32'h40);
    checkEq("retired40", retired, expRetired);

    // PC wrap on seqPC
    doFetch(32'h3333_4444, 32'hFFFF_FFFC, 1'b0, 1'b0);
    checkEq("curPCtop", curPC, 32'hFFFF_FFFC);
    checkEq("seqPCwrap", seqPC, 32'h0);
    doFetch(32'h5555_6666, 32'h0, 1'b0, 1'b0);
    checkEq("addrWrap0", imemAddr, 32'h0);

    // halt beats simultaneous start
    doFetch(32'h7777_8888, 32'h20, 1'b1, 1'b1);
    checkEq("haltNoReq", imemReq, 1'b0);
    checkEq("haltIValid", instrValid, 1'b0);
    checkEq("haltPC", curPC, 32'h20);
    tick();
    checkEq("haltStay", imemReq, 1'b0);
    checkEq("haltInstrHeld", instr, 32'h7777_8888);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkEq("resumeReq", imemReq, 1'b1);
    checkEq("resumeAddr", imemAddr, 32'h20);

    // Misaligned target
    doFetch(32'h9999_AAAA, 32'h12, 1'b0, 1'b0);
    checkEq("faultSet", fault, 1'b1);
    checkEq("faultPC", curPC, 32'h20);
    checkEq("faultNoReq", imemReq, 1'b0);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    checkEq("faultStartIgn", imemReq, 1'b0);
    checkEq("faultSticky", fault, 1'b1);

    // Reset clears fault and restarts
    rst = 1'b1;
    #1;
    checkEq("faultClr", fault, 1'b0);
    rst = 1'b0;
    expRetired = 32'd0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkEq("req2", imemReq, 1'b1);
    imemGnt = 1'b1;
    tick();
    imemGnt = 1'b0;
    // Asynchronous reset while in WAIT
    rst = 1'b1;
    #1;
    checkEq("midRstIValid", instrValid, 1'b0);
    checkEq("midRstPC", curPC, 32'h0);
    checkEq("midRstRetired", retired, 32'h0);
    tick();
    rst = 1'b0;
    imemValid = 1'b1;
    imemData  = 32'hDEAD_BEEF;
    tick();
    imemValid = 1'b0;
    tick();
    checkEq("dropIValid", instrValid, 1'b0);
    checkEq("dropReq", imemReq, 1'b0);
    checkEq("dropInstr", instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch stage sitting directly upstream of `branch_unit`. It owns the architectural PC register, fetches one instruction at a time from instruction memory over a request/grant/valid handshake, and presents it to decode. It drives `branch_unit`'s `PC` input with the sequential address and consumes its `nextAddr` to load the PC once the held instruction retires.

## Interface
- `ADDR_W`, 32, address and data width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `PC_STEP`, 4, byte increment between sequential instructions
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: leave IDLE/HALTED and begin fetching at current PC
- `halt` in 1: stop after the instruction retiring this cycle
- `seqPC` out 32: PC + PC_STEP, feeds `branch_unit.PC`
- `curPC` out 32: PC of the held instruction
- `nextAddr` in 32: resolved next address from `branch_unit`
- `nextValid` in 1: `nextAddr` is valid for the held instruction
- `imemReq` out 1, `imemAddr` out 32: memory request and address
- `imemGnt` in 1: memory accepted the request
- `imemValid` in 1, `imemData` in 32: memory response
- `instr` out 32, `instrValid` out 1, `instrReady` in 1: to decode
- `fault` out 1: sticky misaligned-target flag
- `retired` out 32: count of retired instructions

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALTED.
- IDLE: `start` -> REQ.
- REQ: `imemReq`=1, `imemAddr`=PC. `imemGnt` -> WAIT. `imemValid` is ignored in REQ.
- WAIT: `imemValid` -> capture `imemData` into `instr`, go to HOLD.
- HOLD: `instrValid`=1. Retire fires when `instrReady && nextValid`.
- On retire: PC <= `nextAddr`, `retired` += 1 (wraps at 2^32).
  - If `nextAddr[1:0]` != 0: PC is not loaded, `fault` <= 1, go to HALTED.
  - Else if `halt`: PC is loaded, go to HALTED.
  - Else: PC is loaded, go to REQ.
- HALTED: `start` -> REQ from the current PC. `fault` is cleared only by `rst`, and `start` is ignored while `fault`=1.
- `seqPC` = PC + PC_STEP modulo 2^32: 32'hFFFF_FFFC gives 32'h0000_0000.
- `instr` holds its value outside HOLD. `instrValid` is 0 outside HOLD.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `instr`=0, `instrValid`=0, `imemReq`=0, `fault`=0, `retired`=0.
- `imemAddr`, `imemReq` and `instrValid` are decoded from registered state. `seqPC` and `curPC` are combinational from the PC register.
- Minimum 3 cycles per instruction: REQ 1 + WAIT 1 + HOLD 1. Memory data arrives no earlier than the cycle after grant.
- An `rst` assertion mid-transaction returns the block to IDLE immediately. Any in-flight `imemValid` is then dropped because it is ignored in IDLE and REQ.
- Simultaneous `halt` and `start` in HOLD: `halt` wins.
- `instrReady` without `nextValid`, or the reverse, does not retire; the block stays in HOLD.

## Structure
- Shared package (`fetch_pkg`):
  - state encoding for IDLE, REQ, WAIT, HOLD, HALTED;
  - `RESET_PC` and `PC_STEP` defaults;
  - alignment mask 2'b11.
- One sub-module, `pc_reg`: 32-bit register with asynchronous active-high reset to `RESET_PC` and a load enable. It is instantiated for PC.
- The FSM, instruction register and retire counter live in `instr_fetch_unit`.

## Test plan
- Reset, `start`, immediate grant, data 1 cycle later (32'h2001_0005); decode returns `nextAddr`=4 with ready -> `imemAddr` 0 then 4, `retired`=1, 3 cycles per instruction.
- In HOLD at PC=32'h10, hold `instrReady`=1 and `nextValid`=0 for 5 cycles, then `nextAddr`=32'h40 -> stays in HOLD with stable `instr`, next request at 32'h40.
- PC=32'hFFFF_FFFC -> `seqPC`=0; retire with `nextAddr`=0 -> next fetch at 0.
- Retire with `nextAddr`=32'h0000_0012 -> `fault`=1, HALTED, PC unchanged, `start` ignored until `rst`.
- Assert `rst` during WAIT, then pulse `imemValid` -> state IDLE, `instrValid`=0, PC=`RESET_PC`, response discarded.
- `halt` with retire at `nextAddr`=32'h20 -> HALTED with PC=32'h20; `start` -> request at 32'h20.
